// File: rtl/zero_one_event_counter.sv
// Purpose : counts zero_one_detector hits over back-to-back windows of WINDOW clocks
//           and posts each window result to a one-entry valid/ready output register.
// Latency : a window result appears on count/count_valid (and alarm) one clock after
//           the window's closing cycle.
// Backpressure: if the output register still holds an unconsumed result at a window
//           close, the new result is dropped and the sticky overrun flag is raised.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   det          hit input (one-cycle pulse per detection), counted only while measuring
//   start        begin measuring; honoured only when idle
//   stop         abort measuring and return to idle; beats start and a window close
//   count        result of the last completed window (saturating at 2**CW-1)
//   count_valid  count holds a result not yet consumed
//   count_ready  consumer accepts count on a cycle with count_valid & count_ready
//   alarm        one-cycle pulse when a completed window's result is >= THRESH
//   overrun      sticky: a completed window result was discarded; cleared by start

module zero_one_event_counter #(
    parameter int CW     = 8,
    parameter int WINDOW = 16,
    parameter int THRESH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          det,
    input  logic          start,
    input  logic          stop,
    output logic [CW-1:0] count,
    output logic          count_valid,
    input  logic          count_ready,
    output logic          alarm,
    output logic          overrun
);

    // Window position counter width; WINDOW >= 2 keeps this at least 1 bit.
    localparam int WW = $clog2(WINDOW);

    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [CW-1:0] ACC_MAX  = {CW{1'b1}};
    localparam logic [31:0]   THR      = 32'(THRESH);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t        state,       state_nxt;
    logic [WW-1:0] win,         win_nxt;
    logic [CW-1:0] acc,         acc_nxt;
    logic [CW-1:0] count_nxt;
    logic          valid_nxt;
    logic          alarm_nxt;
    logic          overrun_nxt;

    // Saturating accumulate of this cycle's hit; also the window result on a close.
    logic [CW-1:0] acc_sum;
    logic          consume;
    logic          res_hit;

    always_comb begin
        acc_sum = acc;
        if (det && (acc != ACC_MAX)) begin
            acc_sum = acc + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign consume = count_valid & count_ready;

    // Threshold compare done at 32 bits so THRESH may exceed the count range
    // (in which case the alarm can never fire).
    assign res_hit = ({{(32-CW){1'b0}}, acc_sum} >= THR);

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        win_nxt     = win;
        acc_nxt     = acc;
        count_nxt   = count;
        valid_nxt   = count_valid;
        alarm_nxt   = 1'b0;
        overrun_nxt = overrun;

        // Consumption applies in every state; a load below overrides it.
        if (consume) begin
            valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = COUNT;
                    win_nxt     = '0;
                    acc_nxt     = '0;
                    overrun_nxt = 1'b0;
                end
            end

            COUNT: begin
                if (stop) begin
                    // Partial window is thrown away: no load, no alarm.
                    state_nxt = IDLE;
                    win_nxt   = '0;
                    acc_nxt   = '0;
                end else if (win == WIN_LAST) begin
                    // Window close: the result includes this cycle's hit.
                    win_nxt   = '0;
                    acc_nxt   = '0;
                    alarm_nxt = res_hit;
                    if (!count_valid || consume) begin
                        count_nxt = acc_sum;
                        valid_nxt = 1'b1;
                    end else begin
                        overrun_nxt = 1'b1;
                    end
                end else begin
                    acc_nxt = acc_sum;
                    win_nxt = win + WW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                win_nxt   = '0;
                acc_nxt   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            win         <= '0;
            acc         <= '0;
            count       <= '0;
            count_valid <= 1'b0;
            alarm       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            win         <= win_nxt;
            acc         <= acc_nxt;
            count       <= count_nxt;
            count_valid <= valid_nxt;
            alarm       <= alarm_nxt;
            overrun     <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_zero_one_event_counter.sv
// Bench for zero_one_event_counter: a CW=8 instance and a CW=3 instance share all
// inputs; both are compared every cycle against a window-level reference model.
// Directed window patterns first, then a long randomized run.

module tb_zero_one_event_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       det;
    logic       start;
    logic       stop;
    logic       count_ready;

    logic [7:0] count8;
    logic       valid8, alarm8, overrun8;
    logic [2:0] count3;
    logic       valid3, alarm3, overrun3;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    zero_one_event_counter #(.CW(8), .WINDOW(16), .THRESH(4)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .det         (det),
        .start       (start),
        .stop        (stop),
        .count       (count8),
        .count_valid (valid8),
        .count_ready (count_ready),
        .alarm       (alarm8),
        .overrun     (overrun8)
    );

    zero_one_event_counter #(.CW(3), .WINDOW(16), .THRESH(4)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .det         (det),
        .start       (start),
        .stop        (stop),
        .count       (count3),
        .count_valid (valid3),
        .count_ready (count_ready),
        .alarm       (alarm3),
        .overrun     (overrun3)
    );

    // ---------------- reference model ----------------
    // Hits are kept as a plain unbounded integer; each width clamps at window close.
    bit running;
    int pos;
    int hits;
    int m_count [2];
    int m_valid [2];
    int m_alarm [2];
    int m_ovr   [2];
    int maxv    [2] = '{255, 7};

    task automatic m_reset();
        running = 0;
        pos     = 0;
        hits    = 0;
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0;
            m_valid[k] = 0;
            m_alarm[k] = 0;
            m_ovr[k]   = 0;
        end
    endtask

    task automatic m_step();
        bit closing;
        int res;
        bit cons;
        closing = 0;
        if (running) begin
            if (stop) begin
                running = 0;
            end else begin
                hits += det;
                if (pos == 15) begin
                    closing = 1;
                end else begin
                    pos++;
                end
            end
        end else if (start) begin
            running = 1;
            pos     = 0;
            hits    = 0;
            m_ovr[0] = 0;
            m_ovr[1] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            cons = (m_valid[k] != 0) && count_ready;
            m_alarm[k] = 0;
            if (cons) m_valid[k] = 0;
            if (closing) begin
                res = (hits > maxv[k]) ? maxv[k] : hits;
                m_alarm[k] = (res >= 4) ? 1 : 0;
                if (m_valid[k] == 0) begin
                    m_count[k] = res;
                    m_valid[k] = 1;
                end else begin
                    m_ovr[k] = 1;
                end
            end
        end
        if (closing) begin
            pos  = 0;
            hits = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else     m_step();
        #1;
        check("count8",   int'(count8),   m_count[0]);
        check("valid8",   int'(valid8),   m_valid[0]);
        check("alarm8",   int'(alarm8),   m_alarm[0]);
        check("overrun8", int'(overrun8), m_ovr[0]);
        check("count3",   int'(count3),   m_count[1]);
        check("valid3",   int'(valid3),   m_valid[1]);
        check("alarm3",   int'(alarm3),   m_alarm[1]);
        check("overrun3", int'(overrun3), m_ovr[1]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_window(input logic [15:0] dmask, input logic [15:0] rmask);
        logic [15:0] d;
        logic [15:0] r;
        d = dmask;
        r = rmask;
        for (int i = 0; i < 16; i++) begin
            det         = d[i];
            count_ready = r[i];
            tick();
        end
        det         = 1'b0;
        count_ready = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        m_reset();
        for (int i = 0; i < n; i++) begin
            det = ~det;
            tick();
        end
        rst = 1'b0;
        det = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        det         = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        count_ready = 1'b1;
        m_reset();

        // Reset with det toggling: all outputs stay low.
        do_reset(6);
        idle_cycles(2);

        // det ignored in IDLE, then three hits in one window.
        det = 1'b1;
        idle_cycles(2);
        det = 1'b0;
        pulse_start();
        run_window(16'h0224, 16'hFFFF);

        // Five hits, one on the closing cycle: alarm pulse.
        run_window(16'h8511, 16'hFFFF);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        idle_cycles(3);

        // Backpressure: second result dropped, overrun set.
        pulse_start();
        run_window(16'h0081, 16'h0000);
        run_window(16'h3F00, 16'h0000);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        idle_cycles(2);

        // Same again but consumer ready on the second close.
        count_ready = 1'b0;
        pulse_start();
        run_window(16'h0081, 16'h0000);
        run_window(16'h3F00, 16'h8000);
        idle_cycles(1);

        // Continuous hits: CW=3 instance saturates at 7.
        run_window(16'hFFFF, 16'hFFFF);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        idle_cycles(2);

        // Stop at win=9: nothing emitted.
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            det = 1'b1;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        det  = 1'b0;
        idle_cycles(20);

        // Reset at win=9.
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            det = 1'b1;
            tick();
        end
        do_reset(2);
        idle_cycles(20);

        // stop and start together while counting: back to IDLE.
        pulse_start();
        idle_cycles(4);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        det   = 1'b1;
        idle_cycles(20);
        det   = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            det         = ($urandom_range(99) < 35);
            count_ready = ($urandom_range(99) < 60);
            start       = ($urandom_range(99) < 6);
            stop        = ($urandom_range(999) < 15);
            if ($urandom_range(999) < 3) begin
                do_reset(1 + $urandom_range(2));
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
